uncache_axi_bridge: RTL and testbench
=====================================

Name:
uncache_axi_bridge

Overview:
- Downstream neighbour of the uncached-access controller: turns its simple single-word rd_req/wr_req handshake into single-beat AXI4 master transactions.
- Returns read data through a one-cycle ret_valid pulse. Signals readiness for the next request through rd_rdy/wr_rdy.
- One transaction outstanding at a time, read or write.

Parameters:
none (32-bit address and data fixed)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd_req  in  1  read request from uncache controller
rd_addr  in  32  read address
rd_size  in  3  AXI ARSIZE for the read
rd_rdy  out  1  bridge idle; rd_req accepted this cycle when both high
ret_valid  out  1  one-cycle pulse, ret_data valid
ret_data  out  32  read data (registered)
wr_req  in  1  write request from uncache controller
wr_addr  in  32  write address
wr_size  in  3  AXI AWSIZE for the write
wr_strb  in  4  byte strobes
wr_data  in  32  write data
wr_rdy  out  1  bridge idle and no rd_req; wr_req accepted when both high
araddr  out  32  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rdata  in  32  AXI read data
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wlast  out  1  AXI W last (equals wvalid, single beat)
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready

Behaviour:
- Top level ties the fixed AXI fields: ARLEN=AWLEN=0, ARBURST=AWBURST=INCR, all IDs=0. RID, RLAST, RRESP and BRESP are not ported; error responses are ignored.
- State machine states: IDLE, AR, R, RET, AW_W, B.
- rd_rdy = (state==IDLE). wr_rdy = (state==IDLE && !rd_req). A read wins when rd_req and wr_req are both high.
- IDLE:
  - on rd_req: capture rd_addr/rd_size into registers, go to AR.
  - on wr_req && wr_rdy: capture addr/size/data/strb into registers, clear the aw_done/w_done flags, go to AW_W.
- AR: arvalid=1 from registers. On arready, go to R.
- R: rready=1. On rvalid, register rdata into ret_data and go to RET.
- RET: ret_valid=1 for exactly this cycle, then go to IDLE. rd_rdy therefore rises the cycle after ret_valid, so the controller has rdata captured before data_ok.
- AW_W:
  - awvalid=!aw_done and wvalid=wlast=!w_done.
  - Each channel drops independently on its own ready, setting its flag.
  - Go to B in the cycle where both handshakes are complete, whether they complete together or in separate cycles.
- B: bready=1. On bvalid, go to IDLE; wr_rdy rises the next cycle.
- AXI payload outputs come only from the capture registers and stay stable while the matching valid is high. Valids never drop before their ready.
- Minimum latencies, with request accepted at cycle T and zero-wait slave:
  - read: arvalid at T+1, rvalid at T+2, ret_valid at T+3, rd_rdy at T+4.
  - write: awvalid/wvalid at T+1, bvalid at T+2, wr_rdy at T+3.
- Reset (async, any state): state=IDLE, all AXI valids/readies=0, ret_valid=0, ret_data=0, capture registers=0, so rd_rdy=wr_rdy=1. Any in-flight transaction is abandoned; the interconnect is reset by the same system reset.

Test Plan:
- Read, zero-wait slave: rd_req with addr 0x1FAF_0000, size 2; slave returns 0xDEAD_BEEF → arvalid at T+1, ret_valid one cycle at T+3 with ret_data=0xDEAD_BEEF, rd_rdy low T+1..T+3 and high at T+4.
- Read with arready delayed 3 cycles and rvalid delayed 2 more → araddr/arsize held stable, exactly one ret_valid pulse, no second AR issued.
- Write, wready 2 cycles before awready: addr 0x1FD0_0004, data 0x1234_5678, strb 4'b0011 → wvalid drops after wready, awvalid held until awready, bready only after both, wr_rdy high the cycle after bvalid.
- rd_req and wr_req high together in IDLE → wr_rdy=0 that cycle, read issued first, then write accepted once the read completes.
- Back-to-back: controller issues a new rd_req in the first cycle rd_rdy returns → accepted immediately, second AR at the next cycle, both returned values correct and in order.
- Assert rst while in R, then again while in AW_W → all valids, rready and ret_valid drop to 0 immediately without waiting for a clock edge, rd_rdy=wr_rdy=1, and a new read completes normally after release.

Source files
------------

// File: rtl/uncache_axi_bridge.sv
// uncache_axi_bridge: converts the uncache controller's single-word rd_req/wr_req
// handshake into single-beat AXI4 master transactions, one outstanding at a time.
// ARLEN/AWLEN=0, ARBURST/AWBURST=INCR and all IDs=0 are tied off where the bridge
// is integrated. RID, RLAST, RRESP and BRESP are not ported, so error responses
// are ignored.
module uncache_axi_bridge (
    input  logic        clk,
    input  logic        rst,
    // uncache controller side
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic [2:0]  rd_size,
    output logic        rd_rdy,
    output logic        ret_valid,
    output logic [31:0] ret_data,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [2:0]  wr_size,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] wr_data,
    output logic        wr_rdy,
    // AXI read address / data
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address / data / response
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RET,
        ST_AW_W,
        ST_B
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic rd_accept;
    logic wr_accept;
    logic aw_fire;
    logic w_fire;

    // Handshake decode; a read wins when both requests arrive together.
    assign rd_rdy    = (state_q == ST_IDLE);
    assign wr_rdy    = (state_q == ST_IDLE) && !rd_req;
    assign rd_accept = rd_rdy && rd_req;
    assign wr_accept = wr_rdy && wr_req;

    // Valids and readies decode straight from state so reset clears them at once.
    assign arvalid   = (state_q == ST_AR);
    assign rready    = (state_q == ST_R);
    assign ret_valid = (state_q == ST_RET);
    assign awvalid   = (state_q == ST_AW_W) && !aw_done_q;
    assign wvalid    = (state_q == ST_AW_W) && !w_done_q;
    assign wlast     = wvalid;
    assign bready    = (state_q == ST_B);
    assign aw_fire   = awvalid && awready;
    assign w_fire    = wvalid && wready;

    // Payloads come only from the capture registers, so they hold under valid.
    assign araddr = addr_q;
    assign arsize = size_q;
    assign awaddr = addr_q;
    assign awsize = size_q;
    assign wdata  = data_q;
    assign wstrb  = strb_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_accept)      state_d = ST_AR;
                else if (wr_accept) state_d = ST_AW_W;
            end
            ST_AR:   if (arready) state_d = ST_R;
            ST_R:    if (rvalid)  state_d = ST_RET;
            ST_RET:  state_d = ST_IDLE;
            ST_AW_W: begin
                // Channels may finish together or in separate cycles.
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_B;
            end
            ST_B:    if (bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture registers; the read and write paths share address/size.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are ordinary flops, not a memory, so they are reset to
        // give deterministic AXI payloads out of reset.
        if (rst) begin
            addr_q <= '0;
            size_q <= '0;
            data_q <= '0;
            strb_q <= '0;
        end else if (rd_accept) begin
            addr_q <= rd_addr;
            size_q <= rd_size;
        end else if (wr_accept) begin
            addr_q <= wr_addr;
            size_q <= wr_size;
            data_q <= wr_data;
            strb_q <= wr_strb;
        end
    end

    // Per-channel completion flags for the write address and data channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (wr_accept) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire)  w_done_q  <= 1'b1;
        end
    end

    // Read data register, presented during the one-cycle ret_valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               ret_data <= '0;
        else if ((state_q == ST_R) && rvalid)  ret_data <= rdata;
    end

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// tb_uncache_axi_bridge: table-driven handshake vectors plus hand-written
// sequences for stalled slaves and mid-transaction reset.
module tb_uncache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_rdy;
    logic        ret_valid;
    logic [31:0] ret_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic        wr_rdy;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uncache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_strb(wr_strb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    // stim = {rd_req, wr_req, arready, rvalid, awready, wready, bvalid}
    // exp  = {rd_rdy, wr_rdy, arvalid, rready, ret_valid, awvalid, wvalid, bready}
    typedef struct packed {
        logic [6:0]  stim;
        logic [31:0] rdata;
        logic [7:0]  exp;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [6:0] stim, input logic [31:0] rd, input logic [7:0] exp,
                       input logic [31:0] exp_ret);
        vec_t v;
        v.stim = stim; v.rdata = rd; v.exp = exp; v.exp_ret = exp_ret;
        tbl.push_back(v);
    endtask

    task automatic clear_in();
        rd_req = 1'b0; wr_req = 1'b0; arready = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rdata = '0;
    endtask

    // Advance to 1 ns after the next rising edge; inputs are driven from here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {rd_rdy, wr_rdy, arvalid, rready, ret_valid, awvalid, wvalid, bready};
    endfunction

    int ret_cnt;
    int ar_cnt;

    initial begin
        rst = 1'b1;
        clear_in();
        rd_addr = 32'h1FAF_0000; rd_size = 3'd2;
        wr_addr = 32'h1FD0_0008; wr_size = 3'd2; wr_data = 32'hA5A5_5A5A; wr_strb = 4'hF;
        #2;
        check("reset_outs", {24'h0, outs()}, {24'h0, 8'b1100_0000});
        check("reset_ret_data", ret_data, 32'h0);
        check("reset_araddr", araddr, 32'h0);
        check("reset_wlast", {31'h0, wlast}, 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Zero-wait read, back-to-back read, zero-wait write, then read+write collision.
        add(7'b1000000, 32'h0,         8'b1000_0000, 32'h0);
        add(7'b0010000, 32'h0,         8'b0010_0000, 32'h0);
        add(7'b0001000, 32'hDEAD_BEEF, 8'b0001_0000, 32'h0);
        add(7'b0000000, 32'h0,         8'b0000_1000, 32'hDEAD_BEEF);
        add(7'b1000000, 32'h0,         8'b1000_0000, 32'h0);
        add(7'b0010000, 32'h0,         8'b0010_0000, 32'h0);
        add(7'b0001000, 32'hCAFE_F00D, 8'b0001_0000, 32'h0);
        add(7'b0000000, 32'h0,         8'b0000_1000, 32'hCAFE_F00D);
        add(7'b0100000, 32'h0,         8'b1100_0000, 32'h0);
        add(7'b0000110, 32'h0,         8'b0000_0110, 32'h0);
        add(7'b0000001, 32'h0,         8'b0000_0001, 32'h0);
        add(7'b1100000, 32'h0,         8'b1000_0000, 32'h0);
        add(7'b0110000, 32'h0,         8'b0010_0000, 32'h0);
        add(7'b0101000, 32'h0BAD_F00D, 8'b0001_0000, 32'h0);
        add(7'b0100000, 32'h0,         8'b0000_1000, 32'h0BAD_F00D);
        add(7'b0100000, 32'h0,         8'b1100_0000, 32'h0);
        add(7'b0000110, 32'h0,         8'b0000_0110, 32'h0);
        add(7'b0000001, 32'h0,         8'b0000_0001, 32'h0);
        add(7'b0000000, 32'h0,         8'b1100_0000, 32'h0);

        cyc();
        for (int i = 0; i < tbl.size(); i++) begin
            {rd_req, wr_req, arready, rvalid, awready, wready, bvalid} = tbl[i].stim;
            rdata = tbl[i].rdata;
            #1;
            check($sformatf("vec%0d_outs", i), {24'h0, outs()}, {24'h0, tbl[i].exp});
            if (tbl[i].exp[3]) check($sformatf("vec%0d_ret_data", i), ret_data, tbl[i].exp_ret);
            if (tbl[i].exp[5]) begin
                check($sformatf("vec%0d_araddr", i), araddr, 32'h1FAF_0000);
                check($sformatf("vec%0d_arsize", i), {29'h0, arsize}, 32'd2);
            end
            if (tbl[i].exp[2]) begin
                check($sformatf("vec%0d_awaddr", i), awaddr, 32'h1FD0_0008);
                check($sformatf("vec%0d_wdata", i), wdata, 32'hA5A5_5A5A);
                check($sformatf("vec%0d_wlast", i), {31'h0, wlast}, 32'd1);
            end
            cyc();
        end

        // Read with arready delayed 3 cycles and rvalid delayed 2 more.
        clear_in();
        rd_req = 1'b1; rd_addr = 32'h1FAF_0010; rd_size = 3'd2;
        #1; cyc();
        rd_req = 1'b0; rd_addr = 32'hFFFF_FFFF; rd_size = 3'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("slow_rd_arvalid", {31'h0, arvalid}, 32'd1);
            check("slow_rd_araddr", araddr, 32'h1FAF_0010);
            check("slow_rd_arsize", {29'h0, arsize}, 32'd2);
            cyc();
        end
        arready = 1'b1; #1;
        check("slow_rd_arvalid_at_ready", {31'h0, arvalid}, 32'd1);
        cyc(); arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("slow_rd_rready", {31'h0, rready}, 32'd1);
            check("slow_rd_no_ar", {31'h0, arvalid}, 32'd0);
            cyc();
        end
        rvalid = 1'b1; rdata = 32'h5555_AAAA; #1; cyc();
        rvalid = 1'b0; rdata = '0;
        ret_cnt = 0; ar_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ret_valid) begin
                ret_cnt++;
                check("slow_rd_ret_data", ret_data, 32'h5555_AAAA);
            end
            if (arvalid) ar_cnt++;
            cyc();
        end
        check("slow_rd_ret_pulses", ret_cnt, 32'd1);
        check("slow_rd_extra_ar", ar_cnt, 32'd0);

        // Write with wready two cycles before awready.
        clear_in();
        wr_req = 1'b1; wr_addr = 32'h1FD0_0004; wr_size = 3'd2;
        wr_data = 32'h1234_5678; wr_strb = 4'b0011;
        #1; cyc();
        wr_req = 1'b0; wr_addr = '0; wr_data = '1; wr_strb = 4'hF; wr_size = 3'd0;
        wready = 1'b1; #1;
        check("wr_awvalid_c1", {31'h0, awvalid}, 32'd1);
        check("wr_wvalid_c1", {31'h0, wvalid}, 32'd1);
        check("wr_wlast_c1", {31'h0, wlast}, 32'd1);
        check("wr_awaddr", awaddr, 32'h1FD0_0004);
        check("wr_awsize", {29'h0, awsize}, 32'd2);
        check("wr_wdata", wdata, 32'h1234_5678);
        check("wr_wstrb", {28'h0, wstrb}, 32'h3);
        cyc(); wready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("wr_wvalid_dropped", {31'h0, wvalid}, 32'd0);
            check("wr_wlast_dropped", {31'h0, wlast}, 32'd0);
            check("wr_awvalid_held", {31'h0, awvalid}, 32'd1);
            check("wr_awaddr_held", awaddr, 32'h1FD0_0004);
            check("wr_no_bready", {31'h0, bready}, 32'd0);
            if (i == 1) awready = 1'b1;
            #1;
            if (i == 1) check("wr_no_bready_at_aw", {31'h0, bready}, 32'd0);
            cyc();
        end
        awready = 1'b0; #1;
        check("wr_bready", {31'h0, bready}, 32'd1);
        check("wr_awvalid_dropped", {31'h0, awvalid}, 32'd0);
        cyc();
        bvalid = 1'b1; #1;
        check("wr_rdy_at_bvalid", {31'h0, wr_rdy}, 32'd0);
        cyc(); bvalid = 1'b0; #1;
        check("wr_rdy_after_b", {31'h0, wr_rdy}, 32'd1);
        cyc();

        // Reset asserted while in R, then while in AW_W.
        clear_in();
        rd_req = 1'b1; rd_addr = 32'h1FAF_0020; #1; cyc();
        rd_req = 1'b0; arready = 1'b1; #1; cyc();
        arready = 1'b0; #1;
        check("rst_r_pre_rready", {31'h0, rready}, 32'd1);
        rst = 1'b1; #1;
        check("rst_r_outs", {24'h0, outs()}, {24'h0, 8'b1100_0000});
        check("rst_r_ret_data", ret_data, 32'h0);
        rst = 1'b0; cyc();
        wr_req = 1'b1; wr_addr = 32'h1FD0_0010; #1; cyc();
        wr_req = 1'b0; #1;
        check("rst_w_pre_awvalid", {31'h0, awvalid}, 32'd1);
        rst = 1'b1; #1;
        check("rst_w_outs", {24'h0, outs()}, {24'h0, 8'b1100_0000});
        check("rst_w_wlast", {31'h0, wlast}, 32'd0);
        check("rst_w_awaddr", awaddr, 32'h0);
        rst = 1'b0; cyc();

        // A fresh read completes normally after reset.
        rd_req = 1'b1; rd_addr = 32'h1FAF_0030; #1; cyc();
        rd_req = 1'b0; arready = 1'b1; #1;
        check("post_rst_arvalid", {31'h0, arvalid}, 32'd1);
        check("post_rst_araddr", araddr, 32'h1FAF_0030);
        cyc(); arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h600D_CAFE; #1; cyc();
        rvalid = 1'b0; rdata = '0; #1;
        check("post_rst_ret_valid", {31'h0, ret_valid}, 32'd1);
        check("post_rst_ret_data", ret_data, 32'h600D_CAFE);
        cyc(); #1;
        check("post_rst_rd_rdy", {31'h0, rd_rdy}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
